mdu_seq: RTL

Iterative multiply/divide sequencer that owns the HI/LO result path of the 5-stage pipeline. It accepts MULT/MULTU/DIV/DIVU operands from the execute stage and computes the 64-bit result over 32 cycles, one bit per cycle. While it works it holds the pipeline through a stall output, then presents the HI/LO pair for exactly one cycle so execute can forward it toward the HI/LO registers.

---
 rtl/mdu_seq.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mdu_seq.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one shift-add or restoring-divide step per
// cycle, sign-corrected HI/LO result presented for one cycle on DONE.
module mdu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       dbg_state
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CW-1:0]      r_cnt;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;

    logic               w_accept;
    logic               w_div0;
    logic               w_last;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_trial;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_step;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    assign w_accept = start & ~flush;
    assign w_div0   = op[1] & (b == '0);
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    // op[0] == 0 selects the signed variants
    assign w_a_neg  = ~op[0] & a[WIDTH-1];
    assign w_b_neg  = ~op[0] & b[WIDTH-1];
    assign w_abs_a  = w_a_neg ? -a : a;
    assign w_abs_b  = w_b_neg ? -b : b;

    // Multiply: acc = {partial product, remaining multiplier bits}
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_b : {WIDTH{1'b0}})};
    assign w_mul_next = {w_sum, r_acc[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend/quotient}; remainder needs one extra bit after the shift
    assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_trial    = w_rem_sh - {1'b0, r_b};
    assign w_div_next = w_trial[WIDTH] ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                       : {w_trial[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

    assign w_step   = r_is_div ? w_div_next : w_mul_next;
    assign w_prod   = r_neg_q ? -w_step : w_step;
    assign w_quot   = w_step[WIDTH-1:0];
    assign w_rem    = w_step[2*WIDTH-1:WIDTH];
    assign w_res_lo = r_is_div ? (r_neg_q ? -w_quot : w_quot) : w_prod[WIDTH-1:0];
    assign w_res_hi = r_is_div ? (r_neg_r ? -w_rem : w_rem) : w_prod[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_div0 ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (flush) begin
                    w_next = S_IDLE;
                end else if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_b      <= '0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_div0) begin
                        r_hi <= a;
                        r_lo <= '1;
                    end else if (w_accept) begin
                        r_is_div <= op[1];
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_cnt    <= '0;
                        r_acc    <= {{WIDTH{1'b0}}, (op[1] ? w_abs_a : w_abs_b)};
                        r_b      <= op[1] ? w_abs_b : w_abs_a;
                    end
                end
                S_CALC: begin
                    if (!flush) begin
                        r_acc <= w_step;
                        r_cnt <= r_cnt + CW'(1);
                        if (w_last) begin
                            r_hi <= w_res_hi;
                            r_lo <= w_res_lo;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // rst gates the combinational issue term so stall drops at once on reset
    assign stall     = ((r_state == S_IDLE) & w_accept & rst) | (r_state == S_CALC);
    assign busy      = (r_state == S_CALC);
    assign done      = (r_state == S_DONE);
    assign hi        = r_hi;
    assign lo        = r_lo;
    assign dbg_state = r_state;

endmodule
